// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the streaming expression checker.
// The optional EXPR_SPACE_SKIP_EN build treats ' ' as whitespace (see expr_seq_checker).
package expr_pkg;

  typedef enum logic [1:0] {
    S_START,
    S_NUM,
    S_CLOSE,
    S_ERR
  } state_e;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_OP,
    C_LPAR,
    C_RPAR,
    C_SPACE,
    C_OTHER
  } char_class_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_LPAR  = 8'h28;
  localparam logic [7:0] CH_RPAR  = 8'h29;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= CH_0) && (ch <= CH_9);
  endfunction

endpackage

// File: rtl/expr_seq_checker_if.sv
// Byte-stream input and status outputs of the expression checker.
// master = byte source / observer, slave = checker.
interface expr_seq_checker_if #(
  parameter int MAX_DEPTH = 7,
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
);
  logic               in_valid;
  logic [7:0]         in;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output in_valid,
    output in,
    input  out,
    input  err,
    input  depth
  );

  modport slave (
    input  in_valid,
    input  in,
    output out,
    output err,
    output depth
  );
endinterface

// File: rtl/expr_char_class.sv
// Combinational ASCII byte classifier for the expression grammar.
// Space is always reported as C_SPACE; the FSM decides whether it is legal.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_e cls
);

  always_comb begin
    cls = C_OTHER;
    if (is_digit(ch)) begin
      cls = C_DIGIT;
    end else begin
      case (ch)
        CH_PLUS, CH_MINUS, CH_STAR: cls = C_OP;
        CH_LPAR:                    cls = C_LPAR;
        CH_RPAR:                    cls = C_RPAR;
        CH_SPACE:                   cls = C_SPACE;
        default:                    cls = C_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/expr_seq_checker.sv
// Streaming Moore checker for "term (op term)*" arithmetic expressions with
// bounded numbers and nesting. Define EXPR_SPACE_SKIP_EN to accept ' ' as whitespace.
module expr_seq_checker
  import expr_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
)(
  input  logic               clk,
  input  logic               clr,
  expr_seq_checker_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  char_class_e        cls;

  expr_char_class u_class (
    .ch  (bus.in),
    .cls (cls)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_START;
      depth_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
    end
  end

  // On any error the counters keep their pre-error values.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    if (bus.in_valid) begin
      case (state_q)
        S_START: begin
          case (cls)
            C_DIGIT: begin
              state_d = S_NUM;
              cnt_d   = CNT_ONE;
            end
            C_LPAR: begin
              if (depth_q == DEPTH_MAX) state_d = S_ERR;
              else                      depth_d = depth_q + DEPTH_ONE;
            end
`ifdef EXPR_SPACE_SKIP_EN
            C_SPACE: ;
`endif
            default: state_d = S_ERR;
          endcase
        end
        S_NUM: begin
          case (cls)
            C_DIGIT: begin
              if (cnt_q == CNT_MAX) state_d = S_ERR;
              else                  cnt_d   = cnt_q + CNT_ONE;
            end
            C_OP: state_d = S_START;
            C_RPAR: begin
              if (depth_q == '0) begin
                state_d = S_ERR;
              end else begin
                state_d = S_CLOSE;
                depth_d = depth_q - DEPTH_ONE;
              end
            end
`ifdef EXPR_SPACE_SKIP_EN
            // A space ends the number, so a following digit is rejected.
            C_SPACE: state_d = S_CLOSE;
`endif
            default: state_d = S_ERR;
          endcase
        end
        S_CLOSE: begin
          case (cls)
            C_OP: state_d = S_START;
            C_RPAR: begin
              if (depth_q == '0) state_d = S_ERR;
              else               depth_d = depth_q - DEPTH_ONE;
            end
`ifdef EXPR_SPACE_SKIP_EN
            C_SPACE: ;
`endif
            default: state_d = S_ERR;
          endcase
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  assign bus.out   = ((state_q == S_NUM) || (state_q == S_CLOSE)) && (depth_q == '0);
  assign bus.err   = (state_q == S_ERR);
  assign bus.depth = depth_q;

endmodule

// File: tb/tb_expr_seq_checker.sv
// Directed self-checking bench for expr_seq_checker (MAX_DIGITS=4, MAX_DEPTH=7).
module tb_expr_seq_checker;

  localparam int MAX_DIGITS = 4;
  localparam int MAX_DEPTH  = 7;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  expr_seq_checker_if #(.MAX_DEPTH(MAX_DEPTH)) bus ();

  expr_seq_checker #(
    .MAX_DIGITS (MAX_DIGITS),
    .MAX_DEPTH  (MAX_DEPTH)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one byte for one rising edge, then settle 1 ns past the edge.
  task automatic step(input logic [7:0] ch, input logic v);
    @(negedge clk);
    bus.in_valid = v;
    bus.in       = ch;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Asynchronous clear between edges; outputs must drop before any edge.
  task automatic pulse_clr(input string name);
    #1 clr = 1'b1;
    #1;
    check({name, ".clr.out"}, 32'(bus.out), 0);
    check({name, ".clr.err"}, 32'(bus.err), 0);
    check({name, ".clr.depth"}, 32'(bus.depth), 0);
    #1 clr = 1'b0;
  endtask

  // Feed s; after each byte compare against '0'/'1' in eo/ee and a digit in ed.
  task automatic run_seq(input string name, input string s, input string eo,
                         input string ee, input string ed);
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1'b1);
      check($sformatf("%s[%0d].out", name, i), 32'(bus.out), 32'(eo[i] - "0"));
      check($sformatf("%s[%0d].err", name, i), 32'(bus.err), 32'(ee[i] - "0"));
      check($sformatf("%s[%0d].depth", name, i), 32'(bus.depth), 32'(ed[i] - "0"));
    end
    $display("seq %-8s \"%s\" -> out=%0b err=%0b depth=%0d", name, s, bus.out, bus.err, bus.depth);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in       = 8'h00;
    #12;
    check("reset.out", 32'(bus.out), 0);
    check("reset.err", 32'(bus.err), 0);
    check("reset.depth", 32'(bus.depth), 0);
    @(negedge clk);
    clr = 1'b0;

    run_seq("sum", "1+2+3+4", "1010101", "0000000", "0000000");

    pulse_clr("pre2");
    run_seq("open", "(1+", "000", "000", "111");
    pulse_clr("mid");
    run_seq("dblop", "1++2", "1000", "0011", "0000");

    pulse_clr("t3");
    run_seq("nest", "(12*(3-4))", "0000000001", "0000000000", "1111222210");

    pulse_clr("t4a");
    run_seq("maxdig", "1234-", "11110", "00000", "00000");
    pulse_clr("t4b");
    run_seq("ovfdig", "12345", "11110", "00001", "00000");

    pulse_clr("t5a");
    run_seq("ovfdep", "((((((((", "00000000", "00000001", "12345677");
    pulse_clr("t5b");
    run_seq("undflw", "1)", "10", "01", "00");
    pulse_clr("t5c");
    run_seq("xclose", "(1))", "0010", "0001", "1100");
    pulse_clr("t5d");
    run_seq("implmul", "(1)2", "0010", "0001", "1100");
    pulse_clr("t5e");
    run_seq("absorb", "1x2+", "1000", "0111", "0000");
    pulse_clr("t5f");
    run_seq("unary", "-1", "00", "11", "00");

    pulse_clr("t5g");
    step(8'h00, 1'b1);
    check("nul.err", 32'(bus.err), 1);
    check("nul.out", 32'(bus.out), 0);

    pulse_clr("t6");
    run_seq("gap7", "7", "1", "0", "0");
    for (int i = 0; i < 3; i++) begin
      step("x", 1'b0);
      check($sformatf("gap[%0d].out", i), 32'(bus.out), 1);
      check($sformatf("gap[%0d].err", i), 32'(bus.err), 0);
      check($sformatf("gap[%0d].depth", i), 32'(bus.depth), 0);
    end
    run_seq("gapend", "*8", "01", "00", "00");

    pulse_clr("sp");
`ifdef EXPR_SPACE_SKIP_EN
    run_seq("space", "1 + 2", "11001", "00000", "00000");
    pulse_clr("sp2");
    run_seq("spdig", "1 2", "110", "001", "000");
`else
    run_seq("space", "1 + 2", "10000", "01111", "00000");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
